// File: rtl/fault_injection_pkg.sv
// Shared definitions for the fault-injection sequencer.
//   fi_state_e    : 2-bit FSM state encoding (IDLE, ARMED, DELAY, INJECT)
//   FI_MODE_*     : corruption mode codes, shared with the test CSR block
//   sat_inc16()   : saturating increment used for the window counter
package fault_injection_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_INJECT = 2'd3
  } fi_state_e;

  localparam logic [1:0] FI_MODE_STUCK = 2'd0;  // stuck-at cfg_value
  localparam logic [1:0] FI_MODE_FLIP  = 2'd1;  // invert the clean bus bits
  localparam logic [1:0] FI_MODE_SA0   = 2'd2;  // stuck-at-0
  localparam logic [1:0] FI_MODE_SA1   = 2'd3;  // stuck-at-1

  localparam int WIN_CNT_W = 16;

  // Window counter stops at all-ones rather than wrapping to zero.
  function automatic logic [WIN_CNT_W-1:0] sat_inc16(input logic [WIN_CNT_W-1:0] v);
    return (v == {WIN_CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fault_injection_timer.sv
// Loadable down-counter shared by the DELAY and INJECT phases.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; holds at zero
//   cnt_o        : current count
//   zero_o       : cnt_o == 0
module fault_injection_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fault_injection_ctrl.sv
// Sequencer for one fault_injection_mux on a datapath bus. Latches a fault
// descriptor on start, optionally waits for a trigger, waits a programmable
// delay, then drives the mux select/mask/data for a programmable window,
// repeating for cfg_repeat+1 windows.
//   nvdla_core_clk/rst : clock, asynchronous active-high reset
//   start, abort, trig : campaign control and trigger event
//   cfg_*              : fault descriptor, latched on an accepted start
//   cdata_in           : clean bus data (used by bit-flip mode)
//   sel_out, fsel_out, fdata_out : to the mux sel / fsel_in / fdata_in
//   busy, done, win_cnt          : status back to the CSR block
module fault_injection_ctrl
  import fault_injection_pkg::*;
#(
  parameter int W     = 18,
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             trig,
  input  logic             cfg_trig_en,
  input  logic [1:0]       cfg_mode,
  input  logic [W-1:0]     cfg_mask,
  input  logic [W-1:0]     cfg_value,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_duration,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic [W-1:0]     cdata_in,
  output logic             sel_out,
  output logic [W-1:0]     fsel_out,
  output logic [W-1:0]     fdata_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      win_cnt
);

  fi_state_e        state_q, state_d;
  logic [1:0]       mode_q;
  logic [W-1:0]     mask_q, value_q;
  logic [CNT_W-1:0] delay_q, dur_q;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [15:0]      win_q, win_d;
  logic             sel_q, sel_d;
  logic [W-1:0]     fsel_q, fsel_d;
  logic             done_q, done_d;
  logic             latch_cfg;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val, tmr_cnt, dur_load;

  fault_injection_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Window length 0 behaves as 1; the timer counts the remaining cycles after entry.
  assign dur_load = (dur_q == '0) ? '0 : dur_q - CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    rep_d        = rep_q;
    win_d        = win_q;
    done_d       = 1'b0;
    latch_cfg    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          latch_cfg = 1'b1;
          rep_d     = cfg_repeat;
          if (cfg_trig_en) begin
            state_d = ST_ARMED;
          end else begin
            // Latched copy isn't valid until after this edge, so load from the input.
            state_d      = ST_DELAY;
            tmr_load     = 1'b1;
            tmr_load_val = cfg_delay;
          end
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (trig) begin
          state_d      = ST_DELAY;
          tmr_load     = 1'b1;
          tmr_load_val = delay_q;
        end
      end
      ST_DELAY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d      = ST_INJECT;
          tmr_load     = 1'b1;
          tmr_load_val = dur_load;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_INJECT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          win_d = sat_inc16(win_q);
          if (rep_q != '0) begin
            // Later windows re-enter DELAY directly; no re-trigger.
            rep_d        = rep_q - REP_W'(1);
            state_d      = ST_DELAY;
            tmr_load     = 1'b1;
            tmr_load_val = delay_q;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs track the next state so they change on the same edge as the FSM.
    sel_d  = (state_d == ST_INJECT);
    fsel_d = sel_d ? mask_q : '0;
  end

  // NOTE: the latched descriptor is reset too, so fdata_out is a known value
  // right after reset even though sel_out masks it.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      mask_q  <= '0;
      value_q <= '0;
      delay_q <= '0;
      dur_q   <= '0;
      rep_q   <= '0;
      win_q   <= '0;
      sel_q   <= 1'b0;
      fsel_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      fsel_q  <= fsel_d;
      done_q  <= done_d;
      if (latch_cfg) begin
        mode_q  <= cfg_mode;
        mask_q  <= cfg_mask;
        value_q <= cfg_value;
        delay_q <= cfg_delay;
        dur_q   <= cfg_duration;
      end
    end
  end

  // Fault data is combinational so bit-flip follows the live bus data.
  always_comb begin
    fdata_out = value_q;
    unique case (mode_q)
      FI_MODE_STUCK: fdata_out = value_q;
      FI_MODE_FLIP:  fdata_out = ~cdata_in;
      FI_MODE_SA0:   fdata_out = '0;
      FI_MODE_SA1:   fdata_out = '1;
      default:       fdata_out = value_q;
    endcase
  end

  assign sel_out  = sel_q;
  assign fsel_out = fsel_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign win_cnt  = win_q;

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Directed testbench for fault_injection_ctrl. Inputs change on the falling
// edge; outputs are sampled on the falling edge after each rising edge.
module tb_fault_injection_ctrl;

  localparam int W     = 18;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, trig, cfg_trig_en;
  logic [1:0]       cfg_mode;
  logic [W-1:0]     cfg_mask, cfg_value, cdata_in;
  logic [CNT_W-1:0] cfg_delay, cfg_duration;
  logic [REP_W-1:0] cfg_repeat;
  logic             sel_out, busy, done;
  logic [W-1:0]     fsel_out, fdata_out;
  logic [15:0]      win_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fault_injection_ctrl #(.W(W), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .start          (start),
    .abort          (abort),
    .trig           (trig),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_mode       (cfg_mode),
    .cfg_mask       (cfg_mask),
    .cfg_value      (cfg_value),
    .cfg_delay      (cfg_delay),
    .cfg_duration   (cfg_duration),
    .cfg_repeat     (cfg_repeat),
    .cdata_in       (cdata_in),
    .sel_out        (sel_out),
    .fsel_out       (fsel_out),
    .fdata_out      (fdata_out),
    .busy           (busy),
    .done           (done),
    .win_cnt        (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference behaviour of the downstream mux.
  function automatic logic [W-1:0] mux_out();
    return sel_out ? ((cdata_in & ~fsel_out) | (fdata_out & fsel_out)) : cdata_in;
  endfunction

  initial begin
    rst = 1'b1; start = 0; abort = 0; trig = 0; cfg_trig_en = 0;
    cfg_mode = 2'd0; cfg_mask = '0; cfg_value = '0; cdata_in = '0;
    cfg_delay = '0; cfg_duration = '0; cfg_repeat = '0;
    tick(); tick();
    check("rst_sel", 32'(sel_out), 32'h0);
    check("rst_fsel", 32'(fsel_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_win", 32'(win_cnt), 32'h0);
    check("rst_fdata", 32'(fdata_out), 32'h0);
    rst = 1'b0;
    tick();

    // T1: delay 3, duration 2, stuck-at value
    cfg_trig_en = 0; cfg_mode = 2'd0; cfg_mask = 18'h00003; cfg_value = 18'h00001;
    cfg_delay = 16'd3; cfg_duration = 16'd2; cfg_repeat = 8'd0;
    start = 1; tick(); start = 0;
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_sel_k", 32'(sel_out), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t1_sel_delay", 32'(sel_out), 32'h0);
    end
    tick();
    check("t1_sel_on", 32'(sel_out), 32'h1);
    check("t1_fsel", 32'(fsel_out), 32'h00003);
    check("t1_fdata", 32'(fdata_out), 32'h00001);
    tick();
    check("t1_sel_on2", 32'(sel_out), 32'h1);
    tick();
    check("t1_sel_off", 32'(sel_out), 32'h0);
    check("t1_fsel_off", 32'(fsel_out), 32'h0);
    check("t1_done", 32'(done), 32'h1);
    check("t1_busy_off", 32'(busy), 32'h0);
    check("t1_win", 32'(win_cnt), 32'h1);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);

    // T2: trigger gating; a trig while idle does nothing
    trig = 1; tick(); trig = 0;
    check("t2_idle_trig", 32'(busy), 32'h0);
    cfg_trig_en = 1; cfg_delay = 16'd0; cfg_duration = 16'd1;
    start = 1; tick(); start = 0;
    check("t2_armed_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_armed_sel", 32'(sel_out), 32'h0);
    end
    trig = 1; tick(); trig = 0;
    check("t2_sel_j", 32'(sel_out), 32'h0);
    tick();
    check("t2_sel_on", 32'(sel_out), 32'h1);
    tick();
    check("t2_sel_off", 32'(sel_out), 32'h0);
    check("t2_done", 32'(done), 32'h1);
    check("t2_win", 32'(win_cnt), 32'h2);

    // T3: bit-flip through the mux
    cfg_trig_en = 0; cfg_mode = 2'd1; cfg_mask = 18'h3FFFF; cdata_in = 18'h2AAAA;
    cfg_delay = 16'd0; cfg_duration = 16'd2;
    start = 1; tick(); start = 0;
    check("t3_sel_k", 32'(sel_out), 32'h0);
    tick();
    check("t3_sel_on", 32'(sel_out), 32'h1);
    check("t3_fsel", 32'(fsel_out), 32'h3FFFF);
    check("t3_fdata", 32'(fdata_out), 32'h15555);
    check("t3_mux", 32'(mux_out()), 32'h15555);
    tick();
    check("t3_sel_on2", 32'(sel_out), 32'h1);
    tick();
    check("t3_done", 32'(done), 32'h1);
    check("t3_win", 32'(win_cnt), 32'h3);
    cdata_in = '0;

    // T4: three one-cycle windows, each preceded by two low cycles
    cfg_mode = 2'd3; cfg_mask = 18'h00FF0; cfg_delay = 16'd1; cfg_duration = 16'd0;
    cfg_repeat = 8'd2;
    start = 1; tick(); start = 0;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick();
      check("t4_sel", 32'(sel_out), (i % 3 == 2) ? 32'h1 : 32'h0);
      check("t4_done", 32'(done), (i == 9) ? 32'h1 : 32'h0);
      check("t4_win", 32'(win_cnt), 32'(3 + i / 3));
      if (i % 3 == 2) check("t4_fdata", 32'(fdata_out), 32'h3FFFF);
    end
    tick();
    check("t4_done_once", 32'(done), 32'h0);
    cfg_repeat = 8'd0;

    // T5: abort mid-window, then start+abort together
    cfg_mode = 2'd2; cfg_mask = 18'h00F0F; cfg_delay = 16'd0; cfg_duration = 16'd10;
    cdata_in = 18'h3FFFF;
    start = 1; tick(); start = 0;
    tick();
    check("t5_sel_on", 32'(sel_out), 32'h1);
    check("t5_fdata", 32'(fdata_out), 32'h0);
    check("t5_mux", 32'(mux_out()), 32'h3F0F0);
    tick(); tick();
    abort = 1; tick(); abort = 0;
    check("t5_abort_sel", 32'(sel_out), 32'h0);
    check("t5_abort_fsel", 32'(fsel_out), 32'h0);
    check("t5_abort_busy", 32'(busy), 32'h0);
    check("t5_abort_done", 32'(done), 32'h0);
    check("t5_abort_win", 32'(win_cnt), 32'h6);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("t5_sa_busy", 32'(busy), 32'h0);
    tick();
    check("t5_sa_busy2", 32'(busy), 32'h0);
    check("t5_sa_done", 32'(done), 32'h0);

    // T6: latched cfg kept, start while busy ignored, async reset mid-window
    cfg_mode = 2'd0; cfg_value = 18'h12345; cfg_mask = 18'h0FFFF; cfg_delay = 16'd2;
    cfg_duration = 16'd5; cdata_in = 18'h00ABC;
    start = 1; tick(); start = 0;
    cfg_mask = '0; cfg_value = '0; cfg_delay = 16'd0; cfg_duration = 16'd1; cfg_mode = 2'd3;
    start = 1; tick(); start = 0;
    check("t6_sel_k1", 32'(sel_out), 32'h0);
    check("t6_busy", 32'(busy), 32'h1);
    tick();
    check("t6_sel_k2", 32'(sel_out), 32'h0);
    tick();
    check("t6_sel_on", 32'(sel_out), 32'h1);
    check("t6_fsel", 32'(fsel_out), 32'h0FFFF);
    check("t6_fdata", 32'(fdata_out), 32'h12345);
    tick();
    check("t6_sel_on2", 32'(sel_out), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_sel", 32'(sel_out), 32'h0);
    check("t6_rst_fsel", 32'(fsel_out), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_win", 32'(win_cnt), 32'h0);
    check("t6_rst_mux", 32'(mux_out()), 32'h00ABC);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
